// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: resolved command
// encoding, the priority decoder and default sizing constants.
package pc_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int STK_DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    CMD_CLR   = 3'd0,
    CMD_STALL = 3'd1,
    CMD_INTR  = 3'd2,
    CMD_RET   = 3'd3,
    CMD_CALL  = 3'd4,
    CMD_LD    = 3'd5,
    CMD_INC   = 3'd6,
    CMD_HOLD  = 3'd7
  } cmd_e;

  // Highest-priority asserted input wins; everything below it is ignored.
  function automatic cmd_e decode_cmd(input logic clr, input logic stall,
                                      input logic intr, input logic ret,
                                      input logic call, input logic ld,
                                      input logic inc);
    if (clr)        return CMD_CLR;
    else if (stall) return CMD_STALL;
    else if (intr)  return CMD_INTR;
    else if (ret)   return CMD_RET;
    else if (call)  return CMD_CALL;
    else if (ld)    return CMD_LD;
    else if (inc)   return CMD_INC;
    else            return CMD_HOLD;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: register array plus occupancy counter. Pushes when
// full and pops when empty are ignored here; the caller reports them.
module pc_ret_stack #(
  parameter int ADDR_W    = 10,
  parameter int STK_DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          top_data,
  output logic [$clog2(STK_DEPTH):0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int IW = $clog2(STK_DEPTH);
  localparam int LW = IW + 1;

  logic [ADDR_W-1:0] mem [STK_DEPTH];
  logic [IW-1:0]     top_idx;

  assign full     = (level == LW'(STK_DEPTH));
  assign empty    = (level == '0);
  assign top_idx  = IW'(level - LW'(1));
  // Registered array read asynchronously, so an entry pushed last cycle is
  // already visible to a pop this cycle.
  assign top_data = mem[top_idx];

  always_ff @(posedge CLK) begin
    if (push && !full)
      mem[level[IW-1:0]] <= push_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      level <= '0;
    else if (clr)
      level <= '0;
    else if (push && !full)
      level <= level + LW'(1);
    else if (pop && !empty)
      level <= level - LW'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch path: priority command decode,
// PC register, call/interrupt return stack and sticky stack error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                STK_DEPTH  = STK_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] INTR_VEC   = '1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       PC_CLR,
  input  logic                       STALL,
  input  logic                       INTR,
  input  logic                       RET,
  input  logic                       CALL,
  input  logic                       LD,
  input  logic                       INC,
  input  logic                       CLR_ERR,
  input  logic [ADDR_W-1:0]          DIN,
  output logic [ADDR_W-1:0]          PC_COUNT,
  output logic [$clog2(STK_DEPTH):0] STK_LEVEL,
  output logic                       STK_EMPTY,
  output logic                       STK_FULL,
  output logic                       STK_OVF,
  output logic                       STK_UNF
);

  cmd_e              cmd;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] push_data;
  logic [ADDR_W-1:0] top_data;
  logic              push_req;
  logic              pop_req;
  logic              ovf_set;
  logic              unf_set;

  assign cmd       = decode_cmd(PC_CLR, STALL, INTR, RET, CALL, LD, INC);
  assign pc_inc    = PC_COUNT + ADDR_W'(1);
  assign push_req  = (cmd == CMD_INTR) || (cmd == CMD_CALL);
  assign pop_req   = (cmd == CMD_RET);
  // An interrupt resumes the interrupted instruction; a call resumes after it.
  assign push_data = (cmd == CMD_INTR) ? PC_COUNT : pc_inc;
  assign ovf_set   = push_req && STK_FULL;
  assign unf_set   = pop_req && STK_EMPTY;

  always_comb begin
    pc_nxt = PC_COUNT;
    case (cmd)
      CMD_CLR:  pc_nxt = RESET_ADDR;
      CMD_INTR: pc_nxt = INTR_VEC;
      CMD_RET:  pc_nxt = STK_EMPTY ? PC_COUNT : top_data;
      CMD_CALL: pc_nxt = DIN;
      CMD_LD:   pc_nxt = DIN;
      CMD_INC:  pc_nxt = pc_inc;
      default:  pc_nxt = PC_COUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PC_COUNT <= RESET_ADDR;
      STK_OVF  <= 1'b0;
      STK_UNF  <= 1'b0;
    end else begin
      PC_COUNT <= pc_nxt;
      STK_OVF  <= ovf_set || (STK_OVF && !CLR_ERR);
      STK_UNF  <= unf_set || (STK_UNF && !CLR_ERR);
    end
  end

  pc_ret_stack #(
    .ADDR_W    (ADDR_W),
    .STK_DEPTH (STK_DEPTH)
  ) u_stack (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (cmd == CMD_CLR),
    .push      (push_req),
    .pop       (pop_req),
    .push_data (push_data),
    .top_data  (top_data),
    .level     (STK_LEVEL),
    .full      (STK_FULL),
    .empty     (STK_EMPTY)
  );

endmodule
